// File: rtl/busca_sar_8_bits.sv
// Successive-approximation search: drives a candidate onto comparator port A and
// resolves the unknown operand on port B MSB-first from the G/L/E flags.
module busca_sar_8_bits #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cmp_G,
  input  logic             cmp_L,
  input  logic             cmp_E,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] iters
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRY  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_d;
  logic [CNT_W-1:0]   iters_d;
  logic               busy_d, done_d, err_d;
  logic               finish;

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= IDX_W'(WIDTH - 1);
      cnt_q   <= '0;
      result  <= '0;
      iters   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      result  <= result_d;
      iters   <= iters_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
    end
  end

  // Candidate is combinational so flags for it are sampled at the very next edge
  always_comb begin
    guess = '0;
    if (state_q == TRY) guess = acc_q | (WIDTH'(1) << idx_q);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    result_d = result;
    iters_d  = iters;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    finish   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          idx_d   = IDX_W'(WIDTH - 1);
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = TRY;
        end
      end
      TRY: begin
        busy_d = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (!$onehot({cmp_G, cmp_L, cmp_E})) begin
          result_d = '0;
          err_d    = 1'b1;
          finish   = 1'b1;
        end else if (cmp_E) begin
          result_d = guess;
          finish   = 1'b1;
        end else if (cmp_L) begin
          acc_d = guess;
          if (idx_q == '0) begin
            result_d = guess;
            finish   = 1'b1;
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end else begin
          if (idx_q == '0) begin
            result_d = acc_q;
            finish   = 1'b1;
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end
        if (finish) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          iters_d = cnt_q + CNT_W'(1);
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_busca_sar_8_bits.sv
// Bench for busca_sar_8_bits: behavioural comparator against a target, vector
// table of searches, and a scoreboard checked whenever done pulses.
module tb_busca_sar_8_bits;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset, start;
  logic             cmp_G, cmp_L, cmp_E;
  logic [WIDTH-1:0] guess, result;
  logic             busy, done, err;
  logic [CNT_W-1:0] iters;
  logic [WIDTH-1:0] target;
  logic             fault;

  typedef struct {
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] iters;
    logic             err;
  } exp_t;

  typedef struct {
    logic [WIDTH-1:0] target;
    int               fault_at;
    int               extra_start;
    logic [WIDTH-1:0] res;
    logic [CNT_W-1:0] it;
    logic             er;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[9];
  int   errors = 0;
  int   checks = 0;

  busca_sar_8_bits #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cmp_G(cmp_G), .cmp_L(cmp_L), .cmp_E(cmp_E),
    .guess(guess), .busy(busy), .done(done), .err(err),
    .result(result), .iters(iters)
  );

  always #5 clk = ~clk;

  // Comparator model; fault forces an illegal G+L combination
  always_comb begin
    if (fault) begin
      {cmp_G, cmp_L, cmp_E} = 3'b110;
    end else begin
      cmp_G = (guess > target);
      cmp_L = (guess < target);
      cmp_E = (guess == target);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest pending expectation
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      check("sb_pending", 32'(sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("sb_result", 32'(result), 32'(e.result));
        check("sb_iters",  32'(iters),  32'(e.iters));
        check("sb_err",    32'(err),    32'(e.err));
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int cyc;
    bit seen;
    @(negedge clk);
    target = v.target;
    start  = 1'b1;
    sbq.push_back('{result: v.res, iters: v.it, err: v.er});
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    seen  = 1'b0;
    while (!seen && cyc <= int'(WIDTH) + 2) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        check("latency", 32'(cyc), 32'(v.it) + 1);
        check("busy_in_done", 32'(busy), 0);
        check("guess_in_done", 32'(guess), 0);
        fault = 1'b0;
        start = (v.extra_start != 0);
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", 32'(done), 0);
        check("start_in_done_ignored", 32'(busy), 0);
      end else begin
        check("busy_in_try", 32'(busy), 1);
        if (cyc == 1) check("first_guess", 32'(guess), 32'(1 << (WIDTH - 1)));
        fault = (cyc == v.fault_at);
        start = (v.extra_start != 0 && cyc == v.extra_start);
        @(negedge clk);
        cyc++;
      end
    end
    fault = 1'b0;
    start = 1'b0;
    check("done_seen", 32'(seen), 1);
  endtask

  initial begin
    logic [WIDTH-1:0] g200 [5];
    int wait_cyc;
    g200[0] = 8'd128; g200[1] = 8'd192; g200[2] = 8'd224; g200[3] = 8'd208; g200[4] = 8'd200;

    //            target fault extra  res    it  er
    vecs[0] = '{8'd200, 0, 0, 8'd200, 4'd5, 1'b0};
    vecs[1] = '{8'd0,   0, 0, 8'd0,   4'd8, 1'b0};
    vecs[2] = '{8'd255, 0, 0, 8'd255, 4'd8, 1'b0};
    vecs[3] = '{8'd128, 0, 0, 8'd128, 4'd1, 1'b0};
    vecs[4] = '{8'd200, 3, 0, 8'd0,   4'd3, 1'b1};
    vecs[5] = '{8'd77,  0, 0, 8'd77,  4'd8, 1'b0};
    vecs[6] = '{8'd1,   0, 0, 8'd1,   4'd8, 1'b0};
    vecs[7] = '{8'd64,  0, 0, 8'd64,  4'd2, 1'b0};
    vecs[8] = '{8'd170, 0, 3, 8'd170, 4'd7, 1'b0};

    reset  = 1'b1;
    start  = 1'b0;
    fault  = 1'b0;
    target = '0;
    repeat (3) @(negedge clk);
    check("rst_guess",  32'(guess),  0);
    check("rst_busy",   32'(busy),   0);
    check("rst_done",   32'(done),   0);
    check("rst_err",    32'(err),    0);
    check("rst_result", 32'(result), 0);
    check("rst_iters",  32'(iters),  0);

    // Reset and start together: start is dropped
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("start_lost_busy", 32'(busy), 0);
    @(negedge clk);
    check("start_lost_idle", 32'(busy), 0);

    // Guess trajectory for target 200
    target = 8'd200;
    start  = 1'b1;
    sbq.push_back('{result: 8'd200, iters: 4'd5, err: 1'b0});
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("g200_guess", 32'(guess), 32'(g200[i]));
      @(negedge clk);
    end
    check("g200_done", 32'(done), 1);
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Reset on the 4th TRY cycle aborts the search silently
    @(negedge clk);
    target = 8'd77;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy",   32'(busy),   0);
    check("abort_guess",  32'(guess),  0);
    check("abort_done",   32'(done),   0);
    check("abort_result", 32'(result), 0);
    check("abort_iters",  32'(iters),  0);
    repeat (12) @(negedge clk);

    // Fresh search with start pulses while busy and during done
    run_vec('{8'd77, 0, 2, 8'd77, 4'd8, 1'b0});
    repeat (3) @(negedge clk);
    check("hold_result", 32'(result), 77);
    check("hold_iters",  32'(iters),  8);

    wait_cyc = 0;
    while (sbq.size() > 0 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("sb_drained", 32'(sbq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
